reg_pwm_timer: RTL and testbench

REG_PWM_TIMER -- requirements
Module: reg_pwm_timer

---
 rtl/reg_pwm_timer.sv | 104 ++++++++++
 tb/tb_reg_pwm_timer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/reg_pwm_timer.sv
// PWM timer with shadowed period/duty registers.
// Loaded values move to the active set at a wrap or at RUN entry.
module reg_pwm_timer #(
  parameter int CNT_W = 16
) (
  input  logic             PCLK,
  input  logic             PRESETN,
  input  logic             en,
  input  logic [CNT_W-1:0] period_in,
  input  logic [CNT_W-1:0] duty_in,
  input  logic             load,
  input  logic             irq_clr,
  output logic             pwm_out,
  output logic [CNT_W-1:0] cnt,
  output logic             period_done,
  output logic             irq,
  output logic             pending
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] act_per_q;
  logic [CNT_W-1:0] act_duty_q;
  logic [CNT_W-1:0] pend_per_q;
  logic [CNT_W-1:0] pend_duty_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] per_d;
  logic [CNT_W-1:0] duty_d;
  logic             xfer;
  logic             wrap;
  logic             pwm_d;
  logic             pend_d;
  logic             irq_d;

  assign wrap        = (state_q == RUN) && (cnt == act_per_q);
  assign period_done = wrap;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    per_d   = act_per_q;
    duty_d  = act_duty_q;
    xfer    = 1'b0;
    pwm_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = RUN;
          xfer    = pending;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
        end else begin
          xfer  = wrap && pending;
          cnt_d = wrap ? '0 : cnt + ONE;
        end
      end
    endcase
    if (xfer) begin
      per_d  = pend_per_q;
      duty_d = pend_duty_q;
    end
    // pwm is a flop, so it is computed from the values cnt/duty are about to take
    if (state_d == RUN) pwm_d = (cnt_d < duty_d);
    pend_d = load | (pending & ~xfer);
    irq_d  = period_done | (irq & ~irq_clr);
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q     <= IDLE;
      cnt         <= '0;
      pwm_out     <= 1'b0;
      irq         <= 1'b0;
      pending     <= 1'b0;
      act_per_q   <= '0;
      act_duty_q  <= '0;
      pend_per_q  <= '0;
      pend_duty_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt        <= cnt_d;
      pwm_out    <= pwm_d;
      irq        <= irq_d;
      pending    <= pend_d;
      act_per_q  <= per_d;
      act_duty_q <= duty_d;
      if (load) begin
        pend_per_q  <= period_in;
        pend_duty_q <= duty_in;
      end
    end
  end

endmodule

// File: tb/tb_reg_pwm_timer.sv
// Directed bench for reg_pwm_timer.
// Expected outputs are queued with each step and checked after the edge.
module tb_reg_pwm_timer;

  localparam int CNT_W = 16;
  localparam int VW    = CNT_W + 4;

  logic             PCLK;
  logic             PRESETN;
  logic             en;
  logic [CNT_W-1:0] period_in;
  logic [CNT_W-1:0] duty_in;
  logic             load;
  logic             irq_clr;
  logic             pwm_out;
  logic [CNT_W-1:0] cnt;
  logic             period_done;
  logic             irq;
  logic             pending;

  reg_pwm_timer #(.CNT_W(CNT_W)) dut (
    .PCLK       (PCLK),
    .PRESETN    (PRESETN),
    .en         (en),
    .period_in  (period_in),
    .duty_in    (duty_in),
    .load       (load),
    .irq_clr    (irq_clr),
    .pwm_out    (pwm_out),
    .cnt        (cnt),
    .period_done(period_done),
    .irq        (irq),
    .pending    (pending)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    string         tag;
    logic [VW-1:0] v;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic expect_o(input string tag, input int c, input bit p,
                          input bit pd, input bit i, input bit pe);
    exp_t e;
    e.tag = tag;
    e.v   = {CNT_W'(c), p, pd, i, pe};
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t          e;
    logic [VW-1:0] obs;
    total++;
    if (sb.size() == 0) begin
      $error("FAIL sb_empty: no expected entry queued");
      return;
    end
    e   = sb.pop_front();
    obs = {cnt, pwm_out, period_done, irq, pending};
    assert (obs === e.v) passed++;
    else $error("FAIL %s: got cnt=%0d pwm=%b pd=%b irq=%b pend=%b, want cnt=%0d pwm=%b pd=%b irq=%b pend=%b",
                e.tag, obs[VW-1:4], obs[3], obs[2], obs[1], obs[0],
                e.v[VW-1:4], e.v[3], e.v[2], e.v[1], e.v[0]);
  endtask

  task automatic step(input string tag, input int c, input bit p,
                      input bit pd, input bit i, input bit pe);
    expect_o(tag, c, p, pd, i, pe);
    @(negedge PCLK);
    pop_check();
  endtask

  initial begin
    PRESETN   = 1'b0;
    en        = 1'b0;
    load      = 1'b0;
    irq_clr   = 1'b0;
    period_in = '0;
    duty_in   = '0;
    #1;
    expect_o("reset", 0, 0, 0, 0, 0);
    pop_check();
    @(negedge PCLK);
    PRESETN = 1'b1;

    // period 4, duty 2
    load = 1; period_in = 4; duty_in = 2;
    step("load_idle", 0, 0, 0, 0, 1);
    load = 0; en = 1;
    step("run_start", 0, 1, 0, 0, 0);
    for (int k = 1; k <= 10; k++)
      step("basic", k % 5, (k % 5) < 2, (k % 5) == 4, k >= 5, 0);
    step("basic", 1, 1, 0, 1, 0);

    // shadow load mid-period
    load = 1; period_in = 9; duty_in = 5;
    step("shadow_ld", 2, 0, 0, 1, 1);
    load = 0;
    step("shadow_wait", 3, 0, 0, 1, 1);
    step("shadow_wait", 4, 0, 1, 1, 1);
    step("shadow_xfer", 0, 1, 0, 1, 0);
    for (int j = 1; j <= 10; j++)
      step("period10", j % 10, (j % 10) < 5, (j % 10) == 9, 1, 0);

    // irq clear alone, then clear colliding with set
    irq_clr = 1;
    step("irq_clr", 1, 1, 0, 0, 0);
    irq_clr = 0;
    for (int c = 2; c <= 9; c++)
      step("irq_low", c, c < 5, c == 9, 0, 0);
    irq_clr = 1;
    step("irq_set_wins", 0, 1, 0, 1, 0);
    irq_clr = 0;

    // en drop at cnt=3
    for (int c = 1; c <= 3; c++)
      step("en_pre", c, 1, 0, 1, 0);
    en = 0;
    step("en_drop", 0, 0, 0, 1, 0);
    step("idle_hold", 0, 0, 0, 1, 0);
    en = 1;
    step("reenable", 0, 1, 0, 1, 0);
    step("reenable", 1, 1, 0, 1, 0);

    // duty 0
    en = 0; load = 1; period_in = 4; duty_in = 0;
    step("d0_ld", 0, 0, 0, 1, 1);
    load = 0; en = 1;
    step("d0_start", 0, 0, 0, 1, 0);
    for (int k = 1; k <= 6; k++)
      step("duty0", k % 5, 0, (k % 5) == 4, 1, 0);

    // duty above period
    en = 0; load = 1; duty_in = 7;
    step("d7_ld", 0, 0, 0, 1, 1);
    load = 0; en = 1;
    step("d7_start", 0, 1, 0, 1, 0);
    for (int k = 1; k <= 6; k++)
      step("duty7", k % 5, 1, (k % 5) == 4, 1, 0);

    // period 0
    en = 0; load = 1; period_in = 0; duty_in = 0;
    step("p0_ld", 0, 0, 0, 1, 1);
    load = 0; en = 1;
    step("p0_start", 0, 0, 1, 1, 0);
    for (int k = 0; k < 3; k++)
      step("p0", 0, 0, 1, 1, 0);

    // load coinciding with a wrap while pending
    load = 1; period_in = 4; duty_in = 2;
    step("ld_a", 0, 0, 1, 1, 1);
    period_in = 3; duty_in = 3;
    step("ld_b_wrap", 0, 1, 0, 1, 1);
    load = 0;
    step("a_run", 1, 1, 0, 1, 1);
    step("a_run", 2, 0, 0, 1, 1);
    step("a_run", 3, 0, 0, 1, 1);
    step("a_run", 4, 0, 1, 1, 1);
    step("b_xfer", 0, 1, 0, 1, 0);
    step("b_run", 1, 1, 0, 1, 0);
    step("b_run", 2, 1, 0, 1, 0);
    step("b_run", 3, 0, 1, 1, 0);
    step("b_run", 0, 1, 0, 1, 0);

    // async reset at cnt=2 with pending
    load = 1; period_in = 6; duty_in = 1;
    step("rst_ld", 1, 1, 0, 1, 1);
    load = 0;
    step("rst_pre", 2, 1, 0, 1, 1);
    #2 PRESETN = 1'b0;
    #1;
    expect_o("async_rst", 0, 0, 0, 0, 0);
    pop_check();
    @(negedge PCLK);
    PRESETN = 1'b1;
    step("post_rst", 0, 0, 1, 0, 0);
    step("post_rst2", 0, 0, 1, 1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
